vmc_wb_burst_slave: RTL and testbench
=====================================

# vmc_wb_burst_slave

Wishbone B3 responder (slave) backed by an on-chip synchronous RAM. It accepts classic single cycles and incrementing bursts (CTI 010) with linear or wrap-4/8/16 addressing (BTE), and returns one acknowledge per beat. It sits on the memory controller's Wishbone ports as a cycle-accurate stand-in and peer target for the port masters, exercising the same adr/we/bte/cti protocol from the responding end.

## Interface
- `ADR_W`, default 10: word-address width of the internal RAM (2^ADR_W × 32-bit words).
- `wb_clk` in 1: the single clock; all state updates on the rising edge.
- `wb_rst_n` in 1: asynchronous, active-low reset.
- `wb_adr_i` in 32: byte address; bits [1:0] ignored.
- `wb_we_i` in 1: 1 = write.
- `wb_bte_i` in 2: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- `wb_cti_i` in 3: 000 classic, 010 incrementing burst, 111 end-of-burst; any other value is reserved.
- `wb_dat_i` in 32: write data.
- `wb_sel_i` in 4: byte-lane enables; bit n covers [8n+7:8n].
- `wb_cyc_i`, `wb_stb_i` in 1 each: cycle and strobe.
- `wb_dat_o` out 32: read data, valid while `wb_ack_o` is high.
- `wb_ack_o` out 1: beat acknowledge.
- `wb_err_o` out 1: error termination.

## Operation
- Request = `wb_cyc_i & wb_stb_i`. Range error = `wb_adr_i[31:ADR_W+2] != 0`. Reserved-CTI error = CTI not in {000, 010, 111}.
- FSM states: IDLE, SINGLE, BURST, ERR. Reset state is IDLE.
- IDLE:
  - Request with range error or reserved CTI -> ERR.
  - Else request with CTI 010 -> BURST. The beat counter loads `wb_adr_i[ADR_W+1:2]`.
  - Else request -> SINGLE.
  - No request -> stay in IDLE.
- SINGLE: `wb_ack_o` = 1 for exactly one cycle, then -> IDLE unconditionally.
- ERR: `wb_err_o` = 1 for one cycle, then -> IDLE. No RAM access occurs.
- BURST:
  - `wb_ack_o = wb_stb_i` (combinational gate on a registered state bit).
  - A beat completes on a cycle with ack & stb. `wb_adr_i` is ignored after the first beat.
  - Next address on each completed beat: linear is adr+1 modulo 2^ADR_W. Wrap-N increments the low log2(N) bits only; upper bits are held.
  - Exit to IDLE after a completed beat with `wb_cti_i` = 111 or 000.
  - Exit to IDLE at once if `wb_cyc_i` falls. Any partial burst is abandoned; writes already completed are kept.
  - `wb_stb_i` low while `wb_cyc_i` is high is a wait state: no ack, counter holds, `wb_dat_o` holds.
- Writes: on each cycle where ack & stb & we, bytes with `wb_sel_i[n]` = 1 are written. Other bytes are unchanged.
- Reads: the RAM is read at the current beat address, so `wb_dat_o` holds that word during the ack cycle. In BURST the read address moves to the next beat address on each completed beat. This makes the next word available in the following cycle with no bubble.
- A write-then-read of the same address in consecutive beats returns the newly written data (write-first).
- Reset is asynchronous and may arrive mid-burst: state returns to IDLE. `wb_ack_o`, `wb_err_o` and `wb_dat_o` go to 0 immediately. RAM contents are not cleared.

## Timing
- Reset values: `wb_ack_o` = 0, `wb_err_o` = 0, `wb_dat_o` = 0, beat counter = 0.
- Classic cycle: request sampled at edge N -> ack high in cycle N+1 -> ack low in N+2. Throughput is 2 cycles per transfer. A stb held high after the ack is treated as a new request at edge N+2.
- Burst: request sampled at edge N -> first ack in N+1 -> one beat per cycle thereafter while stb is high. An L-beat burst with no wait states takes L+1 cycles from first stb to last ack.
- Error: `wb_err_o` high in cycle N+1 only. `wb_ack_o` stays 0.
- `wb_ack_o` and `wb_err_o` are never high in the same cycle.
- No combinational path exists from any input to `wb_dat_o`.

## Test plan
- Classic write then read: write 0xDEADBEEF to 0x10 with sel 1111, then read 0x10 -> ack in the cycle after each stb, read data 0xDEADBEEF; the second cycle after each request shows ack = 0.
- Byte lanes: write 0x11223344 to 0x20 with sel 0101 over an initial 0xFFFFFFFF -> read returns 0xFF22FF44.
- Wrap-4 read burst: starting address 0x38 (word 14), data pre-filled with word index -> 4 back-to-back acks returning 14, 15, 12, 13; ack drops after the CTI 111 beat.
- Linear write burst of 8 with `wb_stb_i` low for 2 cycles after beat 3 -> no ack during the wait cycles; a readback shows 8 consecutive words written correctly.
- Errors: address 0x0001_0000 with ADR_W = 10, and CTI 011 -> `wb_err_o` = 1 for one cycle, `wb_ack_o` = 0, RAM unchanged.
- Reset mid-burst: assert `wb_rst_n` = 0 during beat 2 of a write burst -> ack drops asynchronously; after release a classic request is acked in 1 cycle, and beat 1 data is retained.

Source files
------------

// File: rtl/vmc_wb_burst_slave.sv
// Wishbone B3 burst-capable responder over a synchronous 32-bit RAM.
// Handles classic cycles and incrementing bursts with linear or wrap-4/8/16 addressing.
module vmc_wb_burst_slave #(
  parameter int ADR_W = 10
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_bte_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  typedef enum logic [1:0] {IDLE, SINGLE, BURST, ERR} state_t;

  state_t           state, state_nxt;
  logic [ADR_W-1:0] cnt, cnt_nxt, nxt_adr, rd_adr;
  logic [31:0]      mem [2**ADR_W];
  logic [31:0]      wr_word, rd_word;
  logic             req, rng_err, cti_err, beat, wr_en, rd_ld;
  logic             unused_adr_lsb;

  assign unused_adr_lsb = ^wb_adr_i[1:0];

  assign req     = wb_cyc_i & wb_stb_i;
  assign rng_err = |wb_adr_i[31:ADR_W+2];
  assign cti_err = !(wb_cti_i inside {3'b000, 3'b010, 3'b111});

  assign wb_ack_o = (state == SINGLE) | ((state == BURST) & wb_stb_i);
  assign wb_err_o = (state == ERR);
  assign beat     = wb_ack_o & wb_stb_i;
  assign wr_en    = beat & wb_we_i;

  // Wrap modes only advance the low log2(N) bits of the beat address.
  always_comb begin
    nxt_adr = cnt + 1'b1;
    case (wb_bte_i)
      2'b01:   nxt_adr = {cnt[ADR_W-1:2], cnt[1:0] + 2'd1};
      2'b10:   nxt_adr = {cnt[ADR_W-1:3], cnt[2:0] + 3'd1};
      2'b11:   nxt_adr = {cnt[ADR_W-1:4], cnt[3:0] + 4'd1};
      default: nxt_adr = cnt + 1'b1;
    endcase
  end

  always_comb begin
    wr_word = mem[cnt];
    for (int n = 0; n < 4; n++)
      if (wb_sel_i[n]) wr_word[8*n +: 8] = wb_dat_i[8*n +: 8];
  end

  // Write-first bypass so a read of the word being written sees the new bytes.
  always_comb begin
    rd_adr = (state == IDLE) ? wb_adr_i[ADR_W+1:2] : nxt_adr;
    rd_word = (wr_en && rd_adr == cnt) ? wr_word : mem[rd_adr];
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_ld     = 1'b0;
    case (state)
      IDLE: if (req) begin
        if (rng_err || cti_err) state_nxt = ERR;
        else begin
          cnt_nxt   = wb_adr_i[ADR_W+1:2];
          rd_ld     = 1'b1;
          state_nxt = (wb_cti_i == 3'b010) ? BURST : SINGLE;
        end
      end
      SINGLE: state_nxt = IDLE;
      ERR:    state_nxt = IDLE;
      BURST: begin
        if (!wb_cyc_i) state_nxt = IDLE;
        else if (beat) begin
          cnt_nxt = nxt_adr;
          rd_ld   = 1'b1;
          if (wb_cti_i == 3'b111 || wb_cti_i == 3'b000) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      wb_dat_o <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (rd_ld) wb_dat_o <= rd_word;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wr_en)
      for (int n = 0; n < 4; n++)
        if (wb_sel_i[n]) mem[cnt][8*n +: 8] <= wb_dat_i[8*n +: 8];
  end

endmodule

// File: tb/tb_vmc_wb_burst_slave.sv
// Directed plus randomized bench for vmc_wb_burst_slave against a word-array memory model.
module tb_vmc_wb_burst_slave;
  localparam int ADR_W = 10;
  localparam int DEPTH = 1 << ADR_W;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] adr, dat, dat_o;
  logic        we, cyc, stb, ack, err;
  logic [1:0]  bte;
  logic [2:0]  cti;
  logic [3:0]  sel;

  logic [31:0] model [DEPTH];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  vmc_wb_burst_slave #(.ADR_W(ADR_W)) dut (
    .wb_clk(clk), .wb_rst_n(rst_n), .wb_adr_i(adr), .wb_we_i(we), .wb_bte_i(bte),
    .wb_cti_i(cti), .wb_dat_i(dat), .wb_sel_i(sel), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    checks++;
    assert (!(ack && err)) else begin
      errors++;
      $error("FAIL ack_err_excl: observed ack=%b err=%b expected not both", ack, err);
    end
  end

  initial begin
    #500000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cyc = 0; stb = 0; we = 0; cti = 0; bte = 0; sel = 0; adr = 0; dat = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int n = 0; n < 4; n++) if (s[n]) r[8*n +: 8] = d[8*n +: 8];
    return r;
  endfunction

  // Address of beat b: linear counts modulo depth, wrap-N keeps the aligned N-word block.
  function automatic int beat_adr(input int start, input int mode, input int b);
    int n;
    if (mode == 0) return (start + b) % DEPTH;
    n = 2 << mode;
    return (start & ~(n - 1)) | ((start + b) & (n - 1));
  endfunction

  task automatic single(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] c, input bit exp_err, input string tag, output logic [31:0] rd);
    int wi;
    wi = int'(a[ADR_W+1:2]);
    tick();
    cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s; cti = c; bte = 0;
    @(negedge clk);
    check({tag, "/req_ack"}, 32'(ack), 32'd0);
    tick();
    @(negedge clk);
    rd = dat_o;
    if (exp_err) begin
      check({tag, "/err"}, 32'(err), 32'd1);
      check({tag, "/err_ack"}, 32'(ack), 32'd0);
    end else begin
      check({tag, "/ack"}, 32'(ack), 32'd1);
      if (!w) check({tag, "/rdata"}, dat_o, model[wi]);
      else model[wi] = merge(model[wi], d, s);
    end
    tick();
    idle_bus();
    @(negedge clk);
    check({tag, "/ack_low"}, 32'(ack), 32'd0);
    check({tag, "/err_low"}, 32'(err), 32'd0);
  endtask

  task automatic burst(input logic w, input int start, input int mode, input int len, input int wait_at,
                       input int wait_n, input bit idx_data, input bit rnd_sel, input string tag);
    logic [31:0] wd [$];
    logic [3:0]  ws [$];
    int b, waited, a;
    for (int i = 0; i < len; i++) begin
      wd.push_back(idx_data ? 32'(beat_adr(start, mode, i)) : $urandom);
      ws.push_back(rnd_sel ? 4'($urandom) : 4'hf);
    end
    tick();
    cyc = 1; stb = 1; we = w; adr = 32'(start) << 2; bte = 2'(mode); cti = 3'b010;
    dat = wd[0]; sel = ws[0];
    @(negedge clk);
    check({tag, "/req_ack"}, 32'(ack), 32'd0);
    b = 0; waited = 0;
    while (b < len) begin
      tick();
      a = beat_adr(start, mode, b);
      if (b == wait_at && waited < wait_n) begin
        stb = 0; waited++;
        @(negedge clk);
        check({tag, "/wait_ack"}, 32'(ack), 32'd0);
        if (!w) check({tag, "/wait_dat"}, dat_o, model[a]);
      end else begin
        stb = 1; cti = (b == len - 1) ? 3'b111 : 3'b010;
        dat = wd[b]; sel = ws[b]; adr = $urandom;
        @(negedge clk);
        check({tag, "/beat_ack"}, 32'(ack), 32'd1);
        if (!w) check({tag, "/beat_dat"}, dat_o, model[a]);
        else model[a] = merge(model[a], wd[b], ws[b]);
        b++;
      end
    end
    tick();
    idle_bus();
    @(negedge clk);
    check({tag, "/ack_low"}, 32'(ack), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int len;
    idle_bus();
    #3;
    check("rst/ack", 32'(ack), 32'd0);
    check("rst/err", 32'(err), 32'd0);
    check("rst/dat", dat_o, 32'd0);
    #10 rst_n = 1;

    burst(1, 0, 0, DEPTH, DEPTH, 0, 1, 0, "prefill");

    single(1, 32'h10, 32'hDEADBEEF, 4'hf, 3'b000, 0, "cl_wr", rd);
    single(0, 32'h10, 32'h0, 4'hf, 3'b000, 0, "cl_rd", rd);
    check("cl_rd/const", rd, 32'hDEADBEEF);

    single(1, 32'h20, 32'hFFFFFFFF, 4'hf, 3'b000, 0, "bl_init", rd);
    single(1, 32'h20, 32'h11223344, 4'b0101, 3'b000, 0, "bl_wr", rd);
    single(0, 32'h20, 32'h0, 4'hf, 3'b000, 0, "bl_rd", rd);
    check("bl_rd/const", rd, 32'hFF22FF44);

    burst(0, 14, 1, 4, 4, 0, 0, 0, "wrap4_rd");

    burst(1, 100, 0, 8, 3, 2, 0, 0, "lin8_wr");
    burst(0, 100, 0, 8, 8, 0, 0, 0, "lin8_rd");

    single(1, 32'h0001_0000, 32'hBAD0BAD0, 4'hf, 3'b000, 1, "err_rng", rd);
    single(0, 32'h0, 32'h0, 4'hf, 3'b000, 0, "err_rng_rb", rd);
    single(1, 32'h40, 32'hBAD1BAD1, 4'hf, 3'b011, 1, "err_cti", rd);
    single(0, 32'h40, 32'h0, 4'hf, 3'b000, 0, "err_cti_rb", rd);

    // Reset lands in the middle of beat 2 of a write burst.
    tick();
    cyc = 1; stb = 1; we = 1; adr = 32'h100; bte = 0; cti = 3'b010; dat = 32'hA5A5_0001; sel = 4'hf;
    tick();
    @(negedge clk);
    check("rstmid/beat1_ack", 32'(ack), 32'd1);
    model[64] = 32'hA5A5_0001;
    tick();
    dat = 32'h5A5A_0002;
    #2 rst_n = 0;
    #1;
    check("rstmid/ack", 32'(ack), 32'd0);
    check("rstmid/err", 32'(err), 32'd0);
    check("rstmid/dat", dat_o, 32'd0);
    idle_bus();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    single(0, 32'h100, 32'h0, 4'hf, 3'b000, 0, "rstmid_rb1", rd);
    single(0, 32'h104, 32'h0, 4'hf, 3'b000, 0, "rstmid_rb2", rd);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0)
        single(1'($urandom), {20'h0, 10'($urandom), 2'($urandom)}, $urandom, 4'($urandom),
               $urandom_range(0, 1) ? 3'b111 : 3'b000, 0, "rnd_single", rd);
      else begin
        len = $urandom_range(1, 20);
        burst(1'($urandom), $urandom_range(0, DEPTH - 1), $urandom_range(0, 3), len,
              $urandom_range(0, len - 1), $urandom_range(0, 2), 0, 1, "rnd_burst");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
